// File: rtl/wb_stage.sv
// Write-back stage: merges EX results and formatted load data into one
// registered register-file write per cycle, and counts accepted results.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EX_VALID,
    output logic             EX_READY,
    input  logic [4:0]       EX_RD,
    input  logic [XLEN-1:0]  EX_RESULT,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [4:0]       LD_RD,
    input  logic [XLEN-1:0]  LD_DATA,
    input  logic [2:0]       LD_FUNCT3,
    input  logic [1:0]       LD_OFF,
    output logic             WE,
    output logic [4:0]       ADD_D,
    output logic [XLEN-1:0]  REG_D,
    output logic             ERR,
    output logic [1:0]       ERR_CAUSE,
    output logic [CNT_W-1:0] RETIRE_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Handshake: a transfer happens on a rising edge with VALID && READY.
    // Loads always win (LD_READY = 1); EX waits while LD_VALID is high and
    // must hold its payload stable until EX_READY is seen.
    assign LD_READY = 1'b1;
    assign EX_READY = !LD_VALID;

    logic            ld_acc;
    logic            ex_acc;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic            ld_mis;
    logic            ld_ill;

    assign ld_acc = LD_VALID;
    assign ex_acc = EX_VALID && !LD_VALID;

    always_comb begin
        ld_byte = LD_DATA[7:0];
        case (LD_OFF)
            2'd0: ld_byte = LD_DATA[7:0];
            2'd1: ld_byte = LD_DATA[15:8];
            2'd2: ld_byte = LD_DATA[23:16];
            2'd3: ld_byte = LD_DATA[31:24];
            default: ld_byte = LD_DATA[7:0];
        endcase
        ld_half = LD_OFF[1] ? LD_DATA[31:16] : LD_DATA[15:0];
    end

    // Illegal funct3 takes precedence over misalignment at the write stage.
    always_comb begin
        ld_fmt = '0;
        ld_mis = 1'b0;
        ld_ill = 1'b0;
        case (LD_FUNCT3)
            3'b000: ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_mis = LD_OFF[0];
            end
            3'b101: begin
                ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
                ld_mis = LD_OFF[0];
            end
            3'b010: begin
                ld_fmt = LD_DATA;
                ld_mis = (LD_OFF != 2'd0);
            end
            default: ld_ill = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WE         <= 1'b0;
            ADD_D      <= '0;
            REG_D      <= '0;
            ERR        <= 1'b0;
            ERR_CAUSE  <= 2'b00;
            RETIRE_CNT <= '0;
        end else if (ld_acc) begin
            RETIRE_CNT <= RETIRE_CNT + CNT_ONE;
            if (ld_ill) begin
                WE        <= 1'b0;
                ERR       <= 1'b1;
                ERR_CAUSE <= 2'b10;
            end else if (ld_mis) begin
                WE        <= 1'b0;
                ERR       <= 1'b1;
                ERR_CAUSE <= 2'b01;
            end else begin
                ERR       <= 1'b0;
                ERR_CAUSE <= 2'b00;
                WE        <= (LD_RD != 5'd0);
                if (LD_RD != 5'd0) begin
                    ADD_D <= LD_RD;
                    REG_D <= ld_fmt;
                end
            end
        end else if (ex_acc) begin
            RETIRE_CNT <= RETIRE_CNT + CNT_ONE;
            ERR        <= 1'b0;
            ERR_CAUSE  <= 2'b00;
            WE         <= (EX_RD != 5'd0);
            if (EX_RD != 5'd0) begin
                ADD_D <= EX_RD;
                REG_D <= EX_RESULT;
            end
        end else begin
            WE        <= 1'b0;
            ERR       <= 1'b0;
            ERR_CAUSE <= 2'b00;
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RISC-V core; sits directly upstream of the register file and drives its write port (WE, ADD_D, REG_D).
- Merges two result sources into at most one register write per cycle:
  - the EX channel, carrying ALU results;
  - the LD channel, carrying raw memory load words.
- Formats load data per funct3 and byte offset, suppresses writes to x0 and faulting loads, and counts retired writes.

Parameters:
- XLEN, 32, datapath width; the register file data width.
- CNT_W, 32, width of the retire counter.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- EX_VALID  in  1  EX result valid.
- EX_READY  out  1  EX result accepted this cycle.
- EX_RD  in  5  EX destination register.
- EX_RESULT  in  XLEN  EX result value.
- LD_VALID  in  1  load result valid.
- LD_READY  out  1  load result accepted this cycle; tied to 1.
- LD_RD  in  5  load destination register.
- LD_DATA  in  XLEN  raw aligned memory word.
- LD_FUNCT3  in  3  load type.
- LD_OFF  in  2  byte offset of the load address.
- WE  out  1  register file write enable; registered.
- ADD_D  out  5  register file write address; registered.
- REG_D  out  XLEN  register file write data; registered.
- ERR  out  1  one-cycle pulse: faulting load dropped.
- ERR_CAUSE  out  2  valid with ERR. 01 = misaligned, 10 = illegal funct3.
- RETIRE_CNT  out  CNT_W  count of accepted results, including x0 and faulting loads.

Behaviour:
- Reset: RST_N low asynchronously clears all state.
  - WE = 0, ADD_D = 0, REG_D = 0, ERR = 0, ERR_CAUSE = 0, RETIRE_CNT = 0.
- Reset mid-operation:
  - A result accepted in the cycle reset asserts is lost; no write issues.
  - After release, the first write can appear one cycle after the first accept.
- Handshake and arbitration:
  - A transfer occurs on a rising edge where VALID and READY are both 1.
  - The load channel has strict priority. LD_READY = 1 always.
  - EX_READY = !LD_VALID; this is combinational.
  - The EX source must hold EX_VALID, EX_RD and EX_RESULT stable until EX_READY is seen.
- Latency:
  - A result accepted at edge N appears on WE/ADD_D/REG_D from edge N until edge N+1.
  - The register file captures it at edge N+1.
  - If no result is accepted at edge N+1, WE returns to 0.
  - Back-to-back accepts produce one write every cycle.
- x0 suppression:
  - An accepted result with rd = 0 gives WE = 0.
  - It still counts in RETIRE_CNT.
  - ADD_D and REG_D hold their previous values.
- Load formatting: byte = LD_DATA[8*OFF+7 : 8*OFF]; half = LD_DATA[16*OFF[1]+15 : 16*OFF[1]].
  - LB 000: byte, sign-extended.
  - LBU 100: byte, zero-extended.
  - LH 001: half, sign-extended.
  - LHU 101: half, zero-extended.
  - LW 010: full word.
- Load faults: no write, ERR = 1 for one cycle (aligned with the would-be write), load still counts in RETIRE_CNT.
  - Misaligned (ERR_CAUSE = 01): LH/LHU with OFF[0] = 1, or LW with OFF != 0.
  - Illegal (ERR_CAUSE = 10): funct3 of 011, 110 or 111.
  - If a load is both illegal and misaligned, illegal takes precedence.
- RETIRE_CNT:
  - Increments by 1 per accepted transfer, at most 1 per cycle since only one transfer occurs per cycle.
  - Wraps modulo 2^CNT_W with no saturation.
- Simultaneous EX and LD valid:
  - The load is written.
  - The EX result is stalled, not dropped, and is written in the first cycle LD_VALID = 0.
- No internal storage beyond the single output register, which is always drained by the register file.

Test Plan:
- Reset: RST_N = 0 mid-stream, asynchronously with no clock edge → WE = 0, ADD_D = 0, REG_D = 0, RETIRE_CNT = 0 immediately.
- EX single: EX_VALID = 1, EX_RD = 1, EX_RESULT = 0x00000001 accepted at edge N → WE = 1, ADD_D = 1, REG_D = 1 until edge N+1; then EX_RD = 2, EX_RESULT = 2 the next cycle → back-to-back writes, RETIRE_CNT = 2.
- Load formatting, with LD_DATA = 0x80FF7F01:
  - LB, OFF 1 → REG_D = 0x0000007F.
  - LB, OFF 2 → 0xFFFFFFFF.
  - LBU, OFF 3 → 0x00000080.
  - LH, OFF 2 → 0xFFFF80FF.
  - LHU, OFF 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Arbitration: LD (rd 5, LW 0x12345678) and EX (rd 6, 0xA) valid in the same cycle → EX_READY = 0; write x5 = 0x12345678 first, then x6 = 0x0000000A next cycle; RETIRE_CNT += 2.
- Suppression:
  - EX_RD = 0 → WE = 0, RETIRE_CNT += 1.
  - LH with OFF 1 → ERR = 1, ERR_CAUSE = 01, WE = 0.
  - funct3 = 111 → ERR = 1, ERR_CAUSE = 10, WE = 0.
- Counter wrap: CNT_W = 4, 17 accepts → RETIRE_CNT = 1.
